btb_assoc: RTL
==============

# btb_assoc

Set-associative branch target buffer with per-entry 2-bit direction counters. It replaces the direct-mapped, single-bit-valid BTB in the fetch stage. Fetch looks up the current PC combinationally and gets hit, predicted-taken and target in the same cycle. The branch-resolution stage writes back the outcome through a single update port, and the block allocates, trains or replaces entries on the following clock edge.

## Interface
- `ENTRIES`, default 64: number of sets; power of two, at least 2.
- `WAYS`, default 2: associativity; one of 1, 2 or 4.
- `TAG_W`, default 12: stored tag width. Requires TAG_W + log2(ENTRIES) + 2 ≤ 32.
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `rdy`  in  1: global ready. While low, no state changes and the lookup outputs are forced to 0.
- `raddr_i`  in  32: fetch PC to look up.
- `hit_o`  out  1: tag match in a valid way.
- `taken_o`  out  1: predict taken; only ever 1 when `hit_o` is 1.
- `target_o`  out  32: predicted target; 0 when `hit_o` is 0.
- `upd_i`  in  1: update strobe from branch resolution.
- `upd_pc_i`  in  32: PC of the resolved branch.
- `upd_taken_i`  in  1: actual direction.
- `upd_target_i`  in  32: actual target.
- `flush_i`  in  1: invalidate all entries.

## Operation
- **Address split:** index = pc[IDX_W+1:2] with IDX_W = log2(ENTRIES); tag = pc[TAG_W+IDX_W+1:IDX_W+2]; pc[1:0] ignored.
- **Per-way state:** valid bit, tag, 32-bit target, 2-bit counter `ctr`.
- **Per-set replacement state:** WAYS-1 tree-PLRU bits; none when WAYS=1.
- **Lookup (combinational):**
  - Compare the tag against all ways of the indexed set.
  - On multiple matches, the lowest-numbered way wins. Allocation never creates duplicates.
  - `taken_o` = hit & ctr[1].
- **Update on hit:**
  - `ctr` saturating increment if taken, decrement if not taken (11 stays 11, 00 stays 00).
  - If taken, overwrite the target.
  - Entry stays valid at ctr=00.
  - Touch PLRU toward the hit way.
- **Update on miss, taken:** allocate the lowest-numbered invalid way; if none, the PLRU victim. Write tag and target, set ctr=10 (weakly taken), set valid, touch PLRU.
- **Update on miss, not taken:** no state change.
- **PLRU touch:** flip the tree bits on the path so they point away from the touched way. For WAYS=2, lru = ~way.
- **Flush:** all valid bits cleared at the next edge. PLRU bits reset to 0.
- **Priority:** `rst_n` low > `rdy` low (freeze) > `flush_i` (any same-cycle update is dropped) > `upd_i`.

## Timing
- **Lookup latency:** 0 cycles, purely combinational from `raddr_i` and stored state.
- **Update visibility:** takes effect at the rising edge where `upd_i`=1 and `rdy`=1, and is visible to lookups from the next cycle. A same-cycle lookup of the same set sees the old contents; there is no write-through bypass.
- **Throughput:** one update per cycle; back-to-back updates to the same set are sequentially consistent.
- **Reset:**
  - Edge with `rst_n`=0 clears all valid and PLRU bits.
  - While `rst_n`=0: `hit_o`=0, `taken_o`=0, `target_o`=0.
  - Tag, target and counter arrays are not reset.
- **Reset mid-operation:** an update presented in the same cycle as `rst_n`=0 is discarded.

## Configuration
- Macro: `BTB_COUNTER_EN`.
- **Defined:** 2-bit counters are implemented as described.
- **Undefined:**
  - No counter storage.
  - `taken_o` = `hit_o`.
  - Not-taken updates on a hit leave the entry untouched (target and PLRU unchanged).
  - Taken updates behave as above, minus counter writes.

## Test plan
Bench uses ENTRIES=64, WAYS=2, TAG_W=12; `BTB_COUNTER_EN` defined unless stated.

- **Reset:** after `rst_n`=0 for 1 cycle, lookup of any PC including 0x0000_1004 -> hit_o=0, taken_o=0, target_o=0.
- **Allocate and train:**
  - Update pc=0x0000_1004, taken, target 0x0000_2000 -> next cycle lookup gives hit=1, taken=1, target=0x0000_2000.
  - Two not-taken updates -> hit=1, taken=0.
  - Two more not-taken -> still hit=1 (ctr saturates at 00).
  - One taken -> taken=0 (ctr=01).
- **Conflict and replacement:** allocate 0x0000_1004 (way 0), then 0x0000_2004 (way 1, same index 1), then hit-update 0x0000_1004. Allocating 0x0000_3004 must evict 0x0000_2004: 0x0000_1004 and 0x0000_3004 hit, 0x0000_2004 misses.
- **Same-cycle read/write and not-taken miss:**
  - Lookup 0x0000_1004 in the same cycle as its first allocating update -> hit_o=0 that cycle, 1 the next.
  - A not-taken update on a miss PC 0x0000_4008 -> still a miss afterwards.
- **Flush and freeze:**
  - `flush_i`=1 together with `upd_i` for a new PC -> every PC, including the updated one, misses next cycle.
  - With `rdy`=0, an update is ignored and hit_o=0.
- **Macro undefined:** after an allocating update, not-taken updates keep taken_o=1 and target unchanged.

Source files
------------

// File: rtl/btb_assoc_if.sv
`default_nettype none
// ==========================================================================
// btb_assoc_if : fetch lookup and branch-resolution update bundle for the BTB
// Revision 1.0
// ==========================================================================
interface btb_assoc_if;
  logic        rdy;
  logic [31:0] raddr_i;
  logic        hit_o;
  logic        taken_o;
  logic [31:0] target_o;
  logic        upd_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        flush_i;

  modport master (
    output rdy, raddr_i, upd_i, upd_pc_i, upd_taken_i, upd_target_i, flush_i,
    input  hit_o, taken_o, target_o
  );

  modport slave (
    input  rdy, raddr_i, upd_i, upd_pc_i, upd_taken_i, upd_target_i, flush_i,
    output hit_o, taken_o, target_o
  );
endinterface
`default_nettype wire

// File: rtl/btb_assoc.sv
`default_nettype none
// ==========================================================================
// btb_assoc : set-associative BTB, tree-PLRU replacement, optional 2-bit
//             direction counters (enabled by macro BTB_COUNTER_EN)
// Revision 1.0
// ==========================================================================
module btb_assoc #(
  parameter int ENTRIES = 64,
  parameter int WAYS    = 2,
  parameter int TAG_W   = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  btb_assoc_if.slave bus
);
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

  logic [WAYS-1:0]   valid_q  [ENTRIES];
  logic [PLRU_W-1:0] plru_q   [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES][WAYS];
  logic [31:0]       target_q [ENTRIES][WAYS];

  logic [IDX_W-1:0]  lk_idx, u_idx;
  logic [TAG_W-1:0]  lk_tag, u_tag;
  logic              lk_hit, lk_taken;
  logic [WAY_W-1:0]  lk_way;
  logic              u_hit, u_inv, u_go, u_alloc, u_train, u_write;
  logic [WAY_W-1:0]  u_hway, u_iway, u_victim, u_way;
  logic [PLRU_W-1:0] plru_d;
  logic              unused_pc_bits;

  assign lk_idx = bus.raddr_i[IDX_W+1:2];
  assign lk_tag = bus.raddr_i[TAG_W+IDX_W+1:IDX_W+2];
  assign u_idx  = bus.upd_pc_i[IDX_W+1:2];
  assign u_tag  = bus.upd_pc_i[TAG_W+IDX_W+1:IDX_W+2];
  assign unused_pc_bits = ^{bus.raddr_i, bus.upd_pc_i};

  // Descending scan so the lowest-numbered matching way wins.
  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    u_hit  = 1'b0;
    u_hway = '0;
    u_inv  = 1'b0;
    u_iway = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit = 1'b1;
        lk_way = WAY_W'(w);
      end
      if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit  = 1'b1;
        u_hway = WAY_W'(w);
      end
      if (!valid_q[u_idx][w]) begin
        u_inv  = 1'b1;
        u_iway = WAY_W'(w);
      end
    end
  end

  generate
    if (WAYS == 1) begin : g_plru1
      always_comb begin
        u_victim = '0;
        plru_d   = plru_q[u_idx];
      end
    end else if (WAYS == 2) begin : g_plru2
      always_comb begin
        u_victim = plru_q[u_idx][0];
        plru_d   = ~u_way;
      end
    end else begin : g_plru4
      // Bit 0 selects the victim half, bits 1/2 the victim within each half.
      always_comb begin
        u_victim  = plru_q[u_idx][0] ? {1'b1, plru_q[u_idx][2]} : {1'b0, plru_q[u_idx][1]};
        plru_d    = plru_q[u_idx];
        plru_d[0] = ~u_way[1];
        if (u_way[1]) plru_d[2] = ~u_way[0];
        else          plru_d[1] = ~u_way[0];
      end
    end
  endgenerate

  assign u_go    = rst_n & bus.rdy & ~bus.flush_i & bus.upd_i;
  assign u_alloc = u_go & ~u_hit & bus.upd_taken_i;
  assign u_way   = u_hit ? u_hway : (u_inv ? u_iway : u_victim);
  assign u_write = u_alloc | u_train;

`ifdef BTB_COUNTER_EN
  logic [1:0] ctr_q [ENTRIES][WAYS];
  logic [1:0] ctr_cur, ctr_d;

  assign ctr_cur  = ctr_q[u_idx][u_way];
  assign u_train  = u_go & u_hit;
  assign lk_taken = ctr_q[lk_idx][lk_way][1];

  always_comb begin
    ctr_d = ctr_cur;
    if (u_alloc) begin
      ctr_d = 2'b10;
    end else if (bus.upd_taken_i) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'd1;
    end else if (ctr_cur != 2'b00) begin
      ctr_d = ctr_cur - 2'd1;
    end
  end
`else
  // Without counters a not-taken hit carries no information worth storing.
  assign u_train  = u_go & u_hit & bus.upd_taken_i;
  assign lk_taken = 1'b1;
`endif

  always_comb begin
    bus.hit_o    = 1'b0;
    bus.taken_o  = 1'b0;
    bus.target_o = '0;
    if (rst_n && bus.rdy && lk_hit) begin
      bus.hit_o    = 1'b1;
      bus.taken_o  = lk_taken;
      bus.target_o = target_q[lk_idx][lk_way];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < ENTRIES; e++) begin
        valid_q[e] <= '0;
        plru_q[e]  <= '0;
      end
    end else if (bus.rdy) begin
      if (bus.flush_i) begin
        for (int e = 0; e < ENTRIES; e++) begin
          valid_q[e] <= '0;
          plru_q[e]  <= '0;
        end
      end else if (u_write) begin
        valid_q[u_idx][u_way] <= 1'b1;
        plru_q[u_idx]         <= plru_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (u_write) begin
      if (u_alloc)         tag_q[u_idx][u_way]    <= u_tag;
      if (bus.upd_taken_i) target_q[u_idx][u_way] <= bus.upd_target_i;
`ifdef BTB_COUNTER_EN
      ctr_q[u_idx][u_way] <= ctr_d;
`endif
    end
  end
endmodule
`default_nettype wire
